// File: rtl/drum_pkg.sv
// Shared types and fixed-point helpers for the drum mesh column engines.
// Samples are signed 1.17; the row address covers up to 512 rows.
package drum_pkg;

   localparam int W    = 18;
   localparam int AW   = 9;
   localparam int HW   = 10;
   localparam int FRAC = 17;

   localparam logic [HW-1:0] MAX_ROWS = 10'd512;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      PRIME_WAIT,
      ROW_RD,
      ROW_WAIT,
      ROW_WR,
      DONE
   } state_t;

   // 1.17 x 1.17 product, keeping bits [34:17] of the 36-bit result.
   // Bit 35 is dropped, so the result wraps rather than saturates.
   function automatic logic signed [W-1:0] fx_mul(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
      logic signed [2*W-1:0] a_ext;
      logic signed [2*W-1:0] b_ext;
      logic signed [2*W-1:0] prod;
      a_ext = (2*W)'(a);
      b_ext = (2*W)'(b);
      prod  = a_ext * b_ext;
      return prod[FRAC+W-1:FRAC];
   endfunction

endpackage

// File: rtl/node_update.sv
// One mesh node update: five-point Laplacian, coupling, leapfrog step and
// optional shift-based damping. Purely combinational so it can also act as
// a reference model at mesh level.
module node_update
   import drum_pkg::*;
(
   input  logic signed [W-1:0] center,
   input  logic signed [W-1:0] down,
   input  logic signed [W-1:0] up,
   input  logic signed [W-1:0] left,
   input  logic signed [W-1:0] right,
   input  logic signed [W-1:0] prev,
   input  logic signed [W-1:0] rho,
   input  logic        [3:0]   eta_shift,
   output logic signed [W-1:0] u_next
);

   logic signed [W+2:0] sum_wide;
   logic signed [W-1:0] lap;
   logic signed [W-1:0] coupled;
   logic signed [W-1:0] leap;

   // Laplacian at W+3 bits so the sum cannot overflow, then wrap back to W.
   always_comb begin
      sum_wide = (W+3)'(left) + (W+3)'(right) + (W+3)'(down) + (W+3)'(up)
               - ((W+3)'(center) <<< 2);
      lap      = sum_wide[W-1:0];
      coupled  = fx_mul(rho, lap);
      leap     = coupled + (center <<< 1) - prev;
      u_next   = (eta_shift == 4'd0) ? leap : leap - (leap >>> eta_shift);
   end

endmodule

// File: rtl/column_node_sweeper.sv
// Per-column time-step engine. Each accepted start_step walks rows
// 0..height-1, reading u(n) and u(n-1), writing u(n+1) into curr and u(n)
// into prev. A three-row window (down/center/up) slides with the row so
// each curr row is read exactly once per sweep.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | waiting for start_step with both memories initialised
// PRIME      | read address 0 of curr on the bus
// PRIME_WAIT | row 0 data arriving; loaded into center on exit
// ROW_RD     | curr row r+1 and prev row r addresses on the bus
// ROW_WAIT   | read data valid; node update computed and registered
// ROW_WR     | write of row r to both memories; advance or finish
// DONE       | step_done pulse, back to IDLE
module column_node_sweeper
   import drum_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_step,
   input  logic                 mem_ready,
   input  logic        [HW-1:0] height,
   input  logic signed [W-1:0]  rho,
   input  logic        [3:0]    eta_shift,
   input  logic signed [W-1:0]  left_u,
   input  logic signed [W-1:0]  right_u,
   input  logic signed [W-1:0]  q_curr,
   input  logic signed [W-1:0]  q_prev,
   output logic        [AW-1:0] rd_addr_curr,
   output logic        [AW-1:0] rd_addr_prev,
   output logic        [AW-1:0] wr_addr,
   output logic                 we_curr,
   output logic                 we_prev,
   output logic signed [W-1:0]  d_curr,
   output logic signed [W-1:0]  d_prev,
   output logic signed [W-1:0]  center_u,
   output logic signed [W-1:0]  amp_out,
   output logic                 busy,
   output logic                 step_done
);

   state_t              state;
   logic [AW-1:0]       r;
   logic [AW-1:0]       r_last;
   logic [AW-1:0]       r_mid;
   logic signed [W-1:0] down;
   logic signed [W-1:0] center;

   logic [HW-1:0]       h_eff;
   logic [AW-1:0]       rn;
   logic                last_row;
   logic signed [W-1:0] up_v;
   logic signed [W-1:0] u_next;

   assign h_eff    = (height > MAX_ROWS) ? MAX_ROWS : height;
   assign rn       = r + AW'(1);
   assign last_row = (r == r_last);
   // The top row has no upper neighbour; the bus value there is ignored.
   assign up_v     = last_row ? '0 : q_curr;
   assign center_u = center;

   node_update u_node (
      .center    (center),
      .down      (down),
      .up        (up_v),
      .left      (left_u),
      .right     (right_u),
      .prev      (q_prev),
      .rho       (rho),
      .eta_shift (eta_shift),
      .u_next    (u_next)
   );

   // Sweep sequencer; every output is registered and set on entry to the
   // state in which it must be seen.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         r            <= '0;
         r_last       <= '0;
         r_mid        <= '0;
         down         <= '0;
         center       <= '0;
         rd_addr_curr <= '0;
         rd_addr_prev <= '0;
         wr_addr      <= '0;
         we_curr      <= 1'b0;
         we_prev      <= 1'b0;
         d_curr       <= '0;
         d_prev       <= '0;
         amp_out      <= '0;
         busy         <= 1'b0;
         step_done    <= 1'b0;
      end else begin
         step_done <= 1'b0;
         we_curr   <= 1'b0;
         we_prev   <= 1'b0;
         case (state)
            IDLE: begin
               if (start_step && mem_ready) begin
                  if (h_eff == '0) begin
                     step_done <= 1'b1;
                  end else begin
                     state        <= PRIME;
                     busy         <= 1'b1;
                     r            <= '0;
                     r_last       <= AW'(h_eff - HW'(1));
                     r_mid        <= AW'(h_eff >> 1);
                     rd_addr_curr <= '0;
                  end
               end
            end
            PRIME: begin
               state <= PRIME_WAIT;
            end
            PRIME_WAIT: begin
               center       <= q_curr;
               down         <= '0;
               // On a single-row column, hold the address instead of
               // touching row 1, which does not belong to this column.
               rd_addr_curr <= (r_last == '0) ? '0 : AW'(1);
               rd_addr_prev <= '0;
               state        <= ROW_RD;
            end
            ROW_RD: begin
               state <= ROW_WAIT;
            end
            ROW_WAIT: begin
               wr_addr <= r;
               we_curr <= mem_ready;
               we_prev <= mem_ready;
               d_curr  <= u_next;
               d_prev  <= center;
               down    <= center;
               center  <= up_v;
               if (r == r_mid) begin
                  amp_out <= u_next;
               end
               state   <= ROW_WR;
            end
            ROW_WR: begin
               if (last_row) begin
                  step_done <= 1'b1;
                  state     <= DONE;
               end else begin
                  r            <= rn;
                  rd_addr_curr <= (rn == r_last) ? rn : rn + AW'(1);
                  rd_addr_prev <= rn;
                  state        <= ROW_RD;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               r     <= '0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_column_node_sweeper.sv
// Directed bench for column_node_sweeper with a behavioural pair of
// 1-cycle-latency memories. Expected values are worked out by hand from the
// node update equations.
module tb_column_node_sweeper;

   logic        clk;
   logic        reset;
   logic        start_step;
   logic        mem_ready;
   logic [9:0]  height;
   logic [17:0] rho;
   logic [3:0]  eta_shift;
   logic [17:0] left_u;
   logic [17:0] right_u;
   logic [17:0] q_curr;
   logic [17:0] q_prev;
   logic [8:0]  rd_addr_curr;
   logic [8:0]  rd_addr_prev;
   logic [8:0]  wr_addr;
   logic        we_curr;
   logic        we_prev;
   logic [17:0] d_curr;
   logic [17:0] d_prev;
   logic [17:0] center_u;
   logic [17:0] amp_out;
   logic        busy;
   logic        step_done;

   logic [17:0] mem_curr  [0:511];
   logic [17:0] mem_prev  [0:511];
   logic [17:0] init_curr [0:511];
   logic [17:0] init_prev [0:511];
   logic        load;

   int n_checks;
   int n_errors;
   int first_done;
   int n_done;
   int n_wr;
   int row1_hits;
   logic [17:0] acc;
   logic        found;

   column_node_sweeper dut (
      .clk          (clk),
      .reset        (reset),
      .start_step   (start_step),
      .mem_ready    (mem_ready),
      .height       (height),
      .rho          (rho),
      .eta_shift    (eta_shift),
      .left_u       (left_u),
      .right_u      (right_u),
      .q_curr       (q_curr),
      .q_prev       (q_prev),
      .rd_addr_curr (rd_addr_curr),
      .rd_addr_prev (rd_addr_prev),
      .wr_addr      (wr_addr),
      .we_curr      (we_curr),
      .we_prev      (we_prev),
      .d_curr       (d_curr),
      .d_prev       (d_prev),
      .center_u     (center_u),
      .amp_out      (amp_out),
      .busy         (busy),
      .step_done    (step_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory pair: synchronous write, registered read data.
   always @(posedge clk) begin
      if (load) begin
         mem_curr <= init_curr;
         mem_prev <= init_prev;
      end else begin
         if (we_curr) mem_curr[wr_addr] <= d_curr;
         if (we_prev) mem_prev[wr_addr] <= d_prev;
      end
      q_curr <= mem_curr[rd_addr_curr];
      q_prev <= mem_prev[rd_addr_prev];
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic fill_mem(input logic [17:0] cval, input logic [17:0] pval);
      for (int i = 0; i < 512; i++) begin
         init_curr[i] = cval;
         init_prev[i] = pval;
      end
   endtask

   task automatic load_mem();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Pulse start_step in cycle 0, optionally again in cycle retrig, and
   // observe a fixed window of cycles mid-cycle.
   task automatic run_step(input int window, input int retrig,
                           output int fd, output int nd, output int nw, output int r1);
      fd = -1; nd = 0; nw = 0; r1 = 0;
      start_step = 1'b1;
      for (int c = 1; c <= window; c++) begin
         @(negedge clk);
         start_step = (c == retrig);
         if (step_done) begin
            nd++;
            if (fd < 0) fd = c;
         end
         if (we_curr || we_prev) nw++;
         if (busy && (rd_addr_curr == 9'd1 || rd_addr_prev == 9'd1 ||
                      (we_curr && wr_addr == 9'd1))) r1++;
      end
      start_step = 1'b0;
   endtask

   function automatic logic [127:0] all_outs();
      return {25'd0, rd_addr_curr, rd_addr_prev, wr_addr, we_curr, we_prev,
              d_curr, d_prev, center_u, amp_out, busy, step_done};
   endfunction

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      reset      = 1'b0;
      start_step = 1'b0;
      mem_ready  = 1'b1;
      height     = 10'd0;
      rho        = 18'h0;
      eta_shift  = 4'd0;
      left_u     = 18'h0;
      right_u    = 18'h0;
      load       = 1'b0;
      fill_mem(18'h0, 18'h0);
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), 128'd0);
      reset = 1'b1;
      load_mem();

      // All-zero column of 30 rows
      height = 10'd30; rho = 18'h04000;
      run_step(100, -1, first_done, n_done, n_wr, row1_hits);
      check("zero_done_cycle", first_done, 93);
      check("zero_done_count", n_done, 1);
      check("zero_writes", n_wr, 30);
      check("zero_amp", amp_out, 18'h0);
      acc = '0;
      for (int i = 0; i < 30; i++) acc = acc | mem_curr[i] | mem_prev[i];
      check("zero_mem", acc, 18'h0);

      // Single impulse, three rows
      fill_mem(18'h0, 18'h0);
      init_curr[1] = 18'h08000;
      load_mem();
      height = 10'd3; rho = 18'h04000; eta_shift = 4'd0;
      run_step(20, -1, first_done, n_done, n_wr, row1_hits);
      check("imp_done_cycle", first_done, 12);
      check("imp_curr0", mem_curr[0], 18'h01000);
      check("imp_curr1", mem_curr[1], 18'h0C000);
      check("imp_curr2", mem_curr[2], 18'h01000);
      check("imp_prev0", mem_prev[0], 18'h0);
      check("imp_prev1", mem_prev[1], 18'h08000);
      check("imp_prev2", mem_prev[2], 18'h0);
      check("imp_amp", amp_out, 18'h0C000);

      // Same impulse with damping shift 4
      load_mem();
      eta_shift = 4'd4;
      run_step(20, -1, first_done, n_done, n_wr, row1_hits);
      check("damp_curr0", mem_curr[0], 18'h00F00);
      check("damp_curr1", mem_curr[1], 18'h0B400);
      check("damp_curr2", mem_curr[2], 18'h00F00);
      check("damp_amp", amp_out, 18'h0B400);
      eta_shift = 4'd0;

      // Single-row column; 2*0.5 wraps to -1.0, row 1 stays untouched
      fill_mem(18'h0, 18'h0);
      init_curr[0] = 18'h10000;
      init_curr[1] = 18'h00AAA;
      load_mem();
      height = 10'd1; rho = 18'h0;
      run_step(10, -1, first_done, n_done, n_wr, row1_hits);
      check("h1_done_cycle", first_done, 6);
      check("h1_curr0", mem_curr[0], 18'h20000);
      check("h1_prev0", mem_prev[0], 18'h10000);
      check("h1_curr1_kept", mem_curr[1], 18'h00AAA);
      check("h1_row1_access", row1_hits, 0);
      check("h1_amp", amp_out, 18'h20000);

      // Neighbour coupling with a nonzero previous value
      fill_mem(18'h0, 18'h0);
      init_prev[0] = 18'h01000;
      load_mem();
      height = 10'd1; rho = 18'h10000; left_u = 18'h02000; right_u = 18'h02000;
      run_step(10, -1, first_done, n_done, n_wr, row1_hits);
      check("nbr_curr0", mem_curr[0], 18'h01000);
      check("nbr_amp", amp_out, 18'h01000);
      left_u = 18'h0; right_u = 18'h0;

      // Retrigger while busy is ignored
      fill_mem(18'h0, 18'h0);
      init_curr[1] = 18'h08000;
      load_mem();
      height = 10'd3; rho = 18'h04000;
      run_step(30, 5, first_done, n_done, n_wr, row1_hits);
      check("busy_retrig_count", n_done, 1);
      check("busy_retrig_cycle", first_done, 12);
      check("busy_retrig_writes", n_wr, 3);

      // start_step without mem_ready is ignored
      mem_ready = 1'b0;
      run_step(10, -1, first_done, n_done, n_wr, row1_hits);
      check("nordy_done_count", n_done, 0);
      check("nordy_writes", n_wr, 0);
      check("nordy_busy", busy, 1'b0);
      mem_ready = 1'b1;

      // Zero height: immediate step_done, no writes
      height = 10'd0;
      run_step(5, -1, first_done, n_done, n_wr, row1_hits);
      check("h0_done_cycle", first_done, 1);
      check("h0_done_count", n_done, 1);
      check("h0_writes", n_wr, 0);

      // Height above 512 clamps to 512
      fill_mem(18'h0, 18'h0);
      load_mem();
      height = 10'd600;
      run_step(1545, -1, first_done, n_done, n_wr, row1_hits);
      check("clamp_done_cycle", first_done, 1539);
      check("clamp_writes", n_wr, 512);

      // Reset during row 5 of a 30-row sweep
      fill_mem(18'h01000, 18'h0);
      load_mem();
      height = 10'd30; rho = 18'h04000;
      start_step = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         start_step = 1'b0;
         if (we_curr && wr_addr == 9'd5) found = 1'b1;
      end
      check("midrst_reached_row5", found, 1'b1);
      reset = 1'b0;
      #1;
      check("midrst_outputs", all_outs(), 128'd0);
      @(negedge clk);
      reset = 1'b1;
      fill_mem(18'h0, 18'h0);
      init_curr[1] = 18'h08000;
      load_mem();
      height = 10'd3;
      run_step(20, -1, first_done, n_done, n_wr, row1_hits);
      check("midrst_rerun_cycle", first_done, 12);
      check("midrst_rerun_curr0", mem_curr[0], 18'h01000);
      check("midrst_rerun_curr1", mem_curr[1], 18'h0C000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
